// File: rtl/mul_cyc_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle control FSM:
// states, instruction classes, opcodes/functs and datapath selects.
package mul_cyc_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    typedef enum logic [3:0] {
        I_R,
        I_ADDI,
        I_ORI,
        I_LW,
        I_SW,
        I_BEQ,
        I_J,
        I_HALT,
        I_ILL
    } ins_e;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_SLT = 3'd4
    } alu_op_e;

    typedef enum logic [1:0] {
        SRCB_REG  = 2'd0,
        SRCB_FOUR = 2'd1,
        SRCB_SEXT = 2'd2,
        SRCB_ZEXT = 2'd3
    } srcb_e;

    typedef enum logic [1:0] {
        PC_ALU = 2'd0,
        PC_BR  = 2'd1,
        PC_JMP = 2'd2
    } pc_src_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

endpackage

// File: rtl/mul_cyc_ctrl_fsm_ins_dec.sv
// Combinational instruction decoder: opcode/funct to
// instruction class, ALU operation and legality.
module mul_cyc_ins_dec
    import mul_cyc_ctrl_fsm_pkg::*;
#(
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic [5:0] op_code,
    input  logic [5:0] funct,
    output ins_e       cls,
    output alu_op_e    alu_op,
    output logic       legal
);

    always_comb begin
        cls    = I_ILL;
        alu_op = ALU_ADD;
        if (op_code == HALT_OP) begin
            cls = I_HALT;
        end else begin
            case (op_code)
                OP_RTYPE: begin
                    cls = I_R;
                    case (funct)
                        F_ADD:   alu_op = ALU_ADD;
                        F_SUB:   alu_op = ALU_SUB;
                        F_AND:   alu_op = ALU_AND;
                        F_OR:    alu_op = ALU_OR;
                        F_SLT:   alu_op = ALU_SLT;
                        default: cls = I_ILL;
                    endcase
                end
                OP_ADDI: cls = I_ADDI;
                OP_ORI: begin
                    cls    = I_ORI;
                    alu_op = ALU_OR;
                end
                OP_LW:   cls = I_LW;
                OP_SW:   cls = I_SW;
                OP_BEQ: begin
                    cls    = I_BEQ;
                    alu_op = ALU_SUB;
                end
                OP_J:    cls = I_J;
                default: cls = I_ILL;
            endcase
        end
    end

    assign legal = (cls != I_ILL) && (cls != I_HALT);

endmodule

// File: rtl/mul_cyc_ctrl_fsm.sv
// Multi-cycle control FSM: sequences fetch, decode, execute,
// memory and write-back; counts retirements, latches halt/illegal.
module mul_cyc_ctrl_fsm
    import mul_cyc_ctrl_fsm_pkg::*;
#(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = 6'h3F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opCode,
    input  logic [5:0]       funct,
    input  logic             aluZero,
    input  logic             memRdy,
    output logic             pcWr,
    output logic             irWr,
    output logic             iorD,
    output logic             memRd,
    output logic             memWr,
    output logic             ifWR,
    output logic             wriReg,
    output logic             memToReg,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       aluOp,
    output logic [1:0]       pcSrc,
    output logic             halted,
    output logic             illegal,
    output logic [CNT_W-1:0] insCnt
);

    state_e           state_q, state_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] ins_cnt_q, ins_cnt_d;
    logic             retire;

    ins_e    cls;
    alu_op_e alu_op;
    logic    legal;

    mul_cyc_ins_dec #(
        .HALT_OP (HALT_OP)
    ) u_dec (
        .op_code (opCode),
        .funct   (funct),
        .cls     (cls),
        .alu_op  (alu_op),
        .legal   (legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IF;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            ins_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            ins_cnt_q <= ins_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        retire  = 1'b0;
        case (state_q)
            S_IF: if (memRdy) state_d = S_ID;
            S_ID: begin
                if (cls == I_HALT) begin
                    state_d = S_HALT;
                end else if (!legal) begin
                    state_d = S_ERR;
                end else if (cls == I_J) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                case (cls)
                    I_BEQ: begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end
                    I_LW, I_SW: state_d = S_MEM;
                    default:    state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (memRdy) begin
                    if (cls == I_SW) begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IF;
        endcase
        halted_d  = halted_q | (state_d == S_HALT);
        illegal_d = illegal_q | (state_d == S_ERR);
        ins_cnt_d = ins_cnt_q + {{(CNT_W-1){1'b0}}, retire};
    end

    always_comb begin
        pcWr     = 1'b0;
        irWr     = 1'b0;
        iorD     = 1'b0;
        memRd    = 1'b0;
        memWr    = 1'b0;
        ifWR     = 1'b0;
        wriReg   = 1'b0;
        memToReg = 1'b0;
        aluSrcB  = SRCB_REG;
        aluOp    = ALU_ADD;
        pcSrc    = PC_ALU;
        case (state_q)
            S_IF: begin
                memRd   = 1'b1;
                aluSrcB = SRCB_FOUR;
                pcWr    = memRdy;
                irWr    = memRdy;
            end
            S_ID: begin
                if (cls == I_J) begin
                    pcWr  = 1'b1;
                    pcSrc = PC_JMP;
                end
            end
            S_EXE: begin
                aluOp = alu_op;
                case (cls)
                    I_ADDI, I_LW, I_SW: aluSrcB = SRCB_SEXT;
                    I_ORI:              aluSrcB = SRCB_ZEXT;
                    I_BEQ: begin
                        pcWr  = aluZero;
                        pcSrc = PC_BR;
                    end
                    default:            aluSrcB = SRCB_REG;
                endcase
            end
            S_MEM: begin
                iorD  = 1'b1;
                memRd = (cls == I_LW);
                // store strobe held back until memory can accept it
                memWr = (cls == I_SW) && memRdy;
            end
            S_WB: begin
                ifWR     = 1'b1;
                wriReg   = (cls != I_R);
                memToReg = (cls == I_LW);
            end
            default: ;
        endcase
    end

    assign halted  = halted_q;
    assign illegal = illegal_q;
    assign insCnt  = ins_cnt_q;

endmodule

// File: tb/tb_mul_cyc_ctrl_fsm.sv
// Directed bench for mul_cyc_ctrl_fsm with a 4-bit retire
// counter so the wrap case is reachable.
module tb_mul_cyc_ctrl_fsm;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [5:0]    opCode = 6'h00;
    logic [5:0]    funct = 6'h00;
    logic          aluZero = 1'b0;
    logic          memRdy = 1'b0;
    logic          pcWr, irWr, iorD, memRd, memWr, ifWR;
    logic          wriReg, memToReg, halted, illegal;
    logic [1:0]    aluSrcB, pcSrc;
    logic [2:0]    aluOp;
    logic [CW-1:0] insCnt;

    int checks = 0;
    int errors = 0;

    mul_cyc_ctrl_fsm #(
        .CNT_W   (CW),
        .HALT_OP (6'h3F)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .opCode   (opCode),
        .funct    (funct),
        .aluZero  (aluZero),
        .memRdy   (memRdy),
        .pcWr     (pcWr),
        .irWr     (irWr),
        .iorD     (iorD),
        .memRd    (memRd),
        .memWr    (memWr),
        .ifWR     (ifWR),
        .wriReg   (wriReg),
        .memToReg (memToReg),
        .aluSrcB  (aluSrcB),
        .aluOp    (aluOp),
        .pcSrc    (pcSrc),
        .halted   (halted),
        .illegal  (illegal),
        .insCnt   (insCnt)
    );

    always #5 clk = ~clk;

    wire [4:0] en = {pcWr, irWr, memRd, memWr, ifWR};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        memRdy  = 1'b1;
        aluZero = 1'b0;
        #1;
    endtask

    task automatic run_ins(input string tag, input logic [5:0] op,
                           input logic [5:0] fn, input int exp_cyc);
        logic [CW-1:0] start;
        logic [CW-1:0] nxt;
        int cyc;
        opCode = op;
        funct  = fn;
        memRdy = 1'b1;
        start  = insCnt;
        nxt    = start + 4'd1;
        cyc    = 0;
        while (insCnt == start && cyc < 20) begin
            step();
            cyc++;
        end
        chk({tag, "_cyc"}, cyc, exp_cyc);
        chk({tag, "_cnt"}, 32'(insCnt), 32'(nxt));
        chk({tag, "_ifen"}, 32'(ifWR), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("rst_iord", iorD, 0);
        chk("rst_memrd", memRd, 1);
        chk("rst_srcb", aluSrcB, 1);
        chk("rst_aluop", aluOp, 0);
        chk("rst_pcwr", pcWr, 0);
        chk("rst_ifwr", ifWR, 0);
        chk("rst_halt", halted, 0);
        chk("rst_ill", illegal, 0);
        chk("rst_cnt", insCnt, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("if_stall_pcwr", pcWr, 0);
        chk("if_stall_irwr", irWr, 0);

        // add, memRdy=1
        opCode = 6'h00; funct = 6'h20; memRdy = 1'b1;
        #1;
        chk("add_if_pcwr", pcWr, 1);
        chk("add_if_irwr", irWr, 1);
        step();
        chk("add_id_ifwr", ifWR, 0);
        chk("add_id_pcwr", pcWr, 0);
        step();
        chk("add_exe_srcb", aluSrcB, 0);
        chk("add_exe_op", aluOp, 0);
        chk("add_exe_ifwr", ifWR, 0);
        step();
        chk("add_wb_ifwr", ifWR, 1);
        chk("add_wb_wri", wriReg, 0);
        chk("add_wb_m2r", memToReg, 0);
        chk("add_wb_cnt", insCnt, 0);
        step();
        chk("add_cnt", insCnt, 1);
        chk("add_if_ifwr", ifWR, 0);

        // reset in the middle of lw MEM
        opCode = 6'h23;
        step(); step(); step();
        chk("lwr_mem_iord", iorD, 1);
        memRdy = 1'b0;
        rst = 1'b1;
        #1;
        chk("lwr_iord", iorD, 0);
        chk("lwr_cnt", insCnt, 0);
        chk("lwr_ifwr", ifWR, 0);
        chk("lwr_memwr", memWr, 0);
        @(negedge clk);
        rst = 1'b0;
        memRdy = 1'b1;
        #1;

        // lw with two memory wait cycles
        opCode = 6'h23;
        step();
        step();
        chk("lw_exe_srcb", aluSrcB, 2);
        step();
        memRdy = 1'b0;
        #1;
        chk("lw_mem_rd", memRd, 1);
        chk("lw_mem_ifwr", ifWR, 0);
        step();
        chk("lw_wait1", iorD, 1);
        step();
        chk("lw_wait2", iorD, 1);
        memRdy = 1'b1;
        step();
        chk("lw_wb_ifwr", ifWR, 1);
        chk("lw_wb_wri", wriReg, 1);
        chk("lw_wb_m2r", memToReg, 1);
        chk("lw_wb_cnt", insCnt, 0);
        step();
        chk("lw_cnt", insCnt, 1);

        // sw store strobe gated by memRdy
        opCode = 6'h2B;
        step(); step(); step();
        chk("sw_mem_wr", memWr, 1);
        memRdy = 1'b0;
        #1;
        chk("sw_stall_wr", memWr, 0);
        memRdy = 1'b1;
        step();
        chk("sw_cnt", insCnt, 2);

        // ori datapath selects
        opCode = 6'h0D;
        step(); step();
        chk("ori_srcb", aluSrcB, 3);
        chk("ori_op", aluOp, 3);
        step();
        chk("ori_wri", wriReg, 1);
        step();

        // beq taken then not taken
        do_reset();
        opCode = 6'h04; aluZero = 1'b1;
        step(); step();
        chk("beq1_pcwr", pcWr, 1);
        chk("beq1_pcsrc", pcSrc, 1);
        chk("beq1_op", aluOp, 1);
        step();
        chk("beq1_cnt", insCnt, 1);
        aluZero = 1'b0;
        step(); step();
        chk("beq0_pcwr", pcWr, 0);
        step();
        chk("beq0_cnt", insCnt, 2);

        run_ins("j", 6'h02, 6'h00, 2);
        run_ins("beq", 6'h04, 6'h00, 3);
        run_ins("addi", 6'h08, 6'h00, 4);
        run_ins("slt", 6'h00, 6'h2A, 4);
        run_ins("lw", 6'h23, 6'h00, 5);

        // halt opcode
        do_reset();
        opCode = 6'h3F;
        step();
        chk("halt_id", halted, 0);
        step();
        chk("halt_set", halted, 1);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("halt_en", en, 0);
        end
        chk("halt_cnt", insCnt, 0);

        // illegal opcode and illegal funct
        do_reset();
        chk("ill_clr", illegal, 0);
        opCode = 6'h3E;
        step(); step();
        chk("ill_op", illegal, 1);
        chk("ill_en", en, 0);
        chk("ill_halt", halted, 0);
        do_reset();
        opCode = 6'h00; funct = 6'h21;
        step(); step();
        chk("ill_fn", illegal, 1);

        // counter wrap
        do_reset();
        for (int i = 0; i < 16; i++) begin
            run_ins("sw_wrap", 6'h2B, 6'h00, 4);
        end
        chk("wrap_cnt", insCnt, 0);
        chk("wrap_ill", illegal, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mul_cyc_ctrl_fsm.md
Name: mul_cyc_ctrl_fsm

Overview:
Multi-cycle control FSM that sequences the datapath around the unified register file: instruction fetch, register read, ALU, memory and register write-back. It drives the register file's read/write phase select (ifWR) and destination select (wriReg), plus PC/IR/memory/ALU controls. It tracks retired instructions and latches halt and illegal-opcode conditions.

Parameters:
CNT_W, 32, width of retired-instruction counter
HALT_OP, 6'h3F, opcode that stops the machine

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
opCode  in  6  IR[31:26], valid from ID onward
funct  in  6  IR[5:0]
aluZero  in  1  ALU zero flag, valid in EXE
memRdy  in  1  memory ready; fetch/data access completes on cycle with memRdy=1
pcWr  out  1  PC write enable
irWr  out  1  IR load enable
iorD  out  1  memory address select: 0=PC, 1=ALU result
memRd  out  1  memory read strobe
memWr  out  1  memory write strobe
ifWR  out  1  register file phase: 0=read (latch A/B), 1=write
wriReg  out  1  register file dest select: 0=rd, 1=rt
memToReg  out  1  write-back data: 0=ALU, 1=memory
aluSrcB  out  2  0=B, 1=const 4, 2=sign-ext imm, 3=zero-ext imm
aluOp  out  3  0=add,1=sub,2=and,3=or,4=slt
pcSrc  out  2  0=ALU(PC+4), 1=branch target, 2=jump target
halted  out  1  sticky halt flag
illegal  out  1  sticky illegal-instruction flag
insCnt  out  CNT_W  retired instruction count

Behaviour:
- States: IF=0, ID=1, EXE=2, MEM=3, WB=4, HALT=5, ERR=6; 3-bit state register; all other outputs combinational from state, opCode, funct, aluZero.
- Reset (async, immediate): state=IF, halted=0, illegal=0, insCnt=0; outputs take IF-state values. Reset mid-instruction abandons it; no partial retire.
- IF: iorD=0, memRd=1, aluSrcB=1, aluOp=add, pcSrc=0. memRdy=0 -> stay IF, pcWr=irWr=0. memRdy=1 -> pcWr=1, irWr=1, next ID.
- ID: ifWR=0 (register file latches rs/rt at this edge). Decode: opCode 0 with funct in {20 add,22 sub,24 and,25 or,2A slt}, 08 addi, 0D ori, 23 lw, 2B sw, 04 beq, 02 j -> EXE; HALT_OP -> HALT; anything else -> ERR. j: pcWr=1, pcSrc=2 in ID, retires, next IF.
- EXE: R-type aluSrcB=0, aluOp from funct -> WB. addi/lw/sw aluSrcB=2, add; ori aluSrcB=3, or -> WB (addi/ori) or MEM (lw/sw). beq: aluSrcB=0, sub; pcWr=aluZero, pcSrc=1; retires, next IF.
- MEM: iorD=1; lw memRd=1, sw memWr=1. memRdy=0 -> stay. memRdy=1: sw retires -> IF; lw -> WB.
- WB: ifWR=1. wriReg=0 for R-type, 1 for addi/ori/lw. memToReg=1 only lw. Retires, next IF. ifWR=0 in every other state.
- Retire: insCnt+1 on the clock edge leaving the last state of each instruction; wraps 2^CNT_W-1 -> 0 silently. HALT/illegal opcodes do not retire.
- Latencies (memRdy=1): j 2, beq 3, R/addi/ori/sw 4, lw 5 cycles; each memRdy=0 cycle in IF/MEM adds one.
- HALT: halted=1, all enables 0, terminal until rst. ERR: illegal=1, all enables 0, terminal until rst.
- memWr, pcWr, irWr, ifWR never asserted simultaneously with memRdy=0 in IF/MEM.

Decomposition:
- Shared package: state encodings, opcode/funct constants, aluOp and aluSrcB/pcSrc encodings.
- One sub-module natural: mul_cyc_ins_dec (combinational opCode/funct -> instruction class + aluOp + legality).

Test Plan:
- Reset during MEM of lw -> state IF, insCnt=0, ifWR=0, memWr=0 immediately (before clk edge).
- add (op 0, funct 20), memRdy=1 -> 4 cycles; ifWR=1 and wriReg=0 only in WB; insCnt 0->1.
- lw (op 23) with memRdy=0 for 2 cycles in MEM -> 7 cycles total; WB ifWR=1, wriReg=1, memToReg=1.
- beq with aluZero=1 then aluZero=0 -> pcWr=1 with pcSrc=1 in first EXE only; both retire, insCnt=2.
- op 3F -> HALT after ID, halted=1, insCnt unchanged, no enables for 10 further cycles; op 3E -> illegal=1, ERR.
- Preload insCnt near wrap (CNT_W=4): 16 sw instructions -> insCnt returns to 0, no glitch on other outputs.
